// File: rtl/bitcoin_pkg.sv
// Shared definitions for the nonce scheduler and the SHA-256 hash workers.
package bitcoin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  localparam int DEFAULT_NUM_NONCES = 16;

  // SHA-256 initial hash value H(0)
  localparam logic [31:0] SHA256_H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // SHA-256 round constants K[0..63]
  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the granted requester on advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic [SW-1:0] sum;

  // Search from the pointer upward with wrap; the lowest offset that requests wins
  always_comb begin
    grant = '0;
    pick  = ptr;
    idx   = '0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      idx = sum[PW-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        pick       = idx;
      end
    end
  end

  // Pointer advances to one past the winner only when the grant is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && (|grant)) begin
      ptr <= (pick == PW'(N - 1)) ? '0 : pick + PW'(1);
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce sweep sequencer: hands nonces to idle hash workers, collects their H0
// results and writes each to output_addr + nonce over a single memory port.
module nonce_scheduler
  import bitcoin_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = DEFAULT_NUM_NONCES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    job_valid,
  input  logic [NUM_CORES-1:0]    job_ready,
  output logic [31:0]             job_nonce,
  input  logic [NUM_CORES-1:0]    res_valid,
  output logic [NUM_CORES-1:0]    res_ready,
  input  logic [32*NUM_CORES-1:0] res_nonce,
  input  logic [32*NUM_CORES-1:0] res_hash,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);

  localparam int            CW    = $clog2(NUM_NONCES + 1);
  localparam logic [CW-1:0] TOTAL = CW'(NUM_NONCES);

  sched_state_t state;
  sched_state_t state_next;

  logic [CW-1:0]        issued;
  logic [CW-1:0]        written;
  logic [15:0]          output_addr_q;
  logic                 run;
  logic                 job_fire;
  logic                 res_fire;
  logic [NUM_CORES-1:0] job_req;
  logic [NUM_CORES-1:0] job_grant;
  logic [NUM_CORES-1:0] res_req;
  logic [NUM_CORES-1:0] res_grant;
  logic [31:0]          sel_nonce;
  logic [31:0]          sel_hash;
  logic                 nonce_hi_unused;

  assign run = (state == ST_RUN);

  // Requests are masked outside RUN so both handshakes are quiet there;
  // dispatch also stops once every nonce has been handed out.
  assign job_req = (run && (issued < TOTAL)) ? job_ready : '0;
  assign res_req = run ? res_valid : '0;

  // A grant is only ever given to a requesting worker, so any grant is a transfer
  assign job_valid = job_grant;
  assign res_ready = res_grant;
  assign job_fire  = |job_grant;
  assign res_fire  = |res_grant;
  assign job_nonce = 32'(issued);
  assign done      = (state == ST_DONE);

  rr_arbiter #(.N(NUM_CORES)) u_dispatch_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (job_req),
    .advance (job_fire),
    .grant   (job_grant)
  );

  rr_arbiter #(.N(NUM_CORES)) u_collect_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (res_req),
    .advance (res_fire),
    .grant   (res_grant)
  );

  // Steer the granted worker's result nonce and hash onto the write path
  always_comb begin
    sel_nonce = '0;
    sel_hash  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (res_grant[i]) begin
        sel_nonce = res_nonce[32*i +: 32];
        sel_hash  = res_hash[32*i +: 32];
      end
    end
  end

  // Only the low 16 nonce bits take part in the 16-bit address
  assign nonce_hi_unused = ^sel_nonce[31:16];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; completion is judged on the registered written count
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (written == TOTAL) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Sweep bookkeeping: base latch and issue/write counters cleared on start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output_addr_q <= '0;
      issued        <= '0;
      written       <= '0;
    end else if ((state == ST_IDLE) && start) begin
      output_addr_q <= output_addr;
      issued        <= '0;
      written       <= '0;
    end else begin
      if (job_fire) issued  <= issued + CW'(1);
      if (res_fire) written <= written + CW'(1);
    end
  end

  // Memory write port: one registered write per accepted result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      mem_we <= res_fire;
      if (res_fire) begin
        mem_addr       <= output_addr_q + sel_nonce[15:0];
        mem_write_data <= sel_hash;
      end
    end
  end

endmodule
